// File: rtl/mult_share_arbiter.sv
// Round-robin front end that shares one sequential 8x8 signed multiplier among
// NREQ requesters. One multiplication is in flight at a time. A watchdog aborts
// the operation and returns an error response if the multiplier never finishes.
module mult_share_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned IDW     = 2,
    parameter int unsigned TIMEOUT = 31
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NREQ-1:0]   req_valid_i,
    input  logic [8*NREQ-1:0] req_m_i,
    input  logic [8*NREQ-1:0] req_r_i,
    output logic [NREQ-1:0]   req_ack_o,
    output logic              rsp_valid_o,
    output logic [IDW-1:0]    rsp_id_o,
    output logic [15:0]       rsp_ans_o,
    output logic              rsp_err_o,
    output logic              busy_o,
    output logic [7:0]        mul_m_o,
    output logic [7:0]        mul_r_o,
    output logic              mul_start_o,
    input  logic              mul_ready_i,
    input  logic [15:0]       mul_ans_i
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    // The abort fires on the edge where the timer would reach TIMEOUT.
    localparam logic [TW-1:0] TimeoutLast = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StLaunch, StWaitDone} state_e;

    state_e           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]   grant_q, grant_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [7:0]       mul_m_q, mul_m_d;
    logic [7:0]       mul_r_q, mul_r_d;
    logic             start_q, start_d;
    logic [NREQ-1:0]  ack_q, ack_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [15:0]      rsp_ans_q, rsp_ans_d;
    logic             rsp_err_q, rsp_err_d;

    logic             win_found;
    logic [IDW-1:0]   win_id;
    logic             hi_found;
    logic [IDW-1:0]   hi_id;
    logic             lo_found;
    logic [IDW-1:0]   lo_id;
    logic [IDW-1:0]   rr_next;

    // Round-robin pick: lowest requester at or above rr_ptr, else lowest overall (wrap).
    always_comb begin
        hi_found = 1'b0;
        hi_id    = '0;
        lo_found = 1'b0;
        lo_id    = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid_i[i]) begin
                lo_found = 1'b1;
                lo_id    = IDW'(i);
                if (i >= int'(rr_ptr_q)) begin
                    hi_found = 1'b1;
                    hi_id    = IDW'(i);
                end
            end
        end
        win_found = lo_found;
        win_id    = hi_found ? hi_id : lo_id;
    end

    // Pointer value after the current grant retires, success or abort.
    always_comb begin
        rr_next = (grant_q == IDW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
    end

    // State register and all datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            timer_q     <= '0;
            mul_m_q     <= '0;
            mul_r_q     <= '0;
            start_q     <= 1'b0;
            ack_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_ans_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            timer_q     <= timer_d;
            mul_m_q     <= mul_m_d;
            mul_r_q     <= mul_r_d;
            start_q     <= start_d;
            ack_q       <= ack_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_ans_q   <= rsp_ans_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Next-state and datapath update: grant, launch handshake, completion, watchdog abort.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        timer_d     = timer_q;
        mul_m_d     = mul_m_q;
        mul_r_d     = mul_r_q;
        start_d     = start_q;
        ack_d       = '0;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_ans_d   = rsp_ans_q;
        rsp_err_d   = rsp_err_q;

        unique case (state_q)
            StIdle: begin
                if (win_found && mul_ready_i) begin
                    mul_m_d        = req_m_i[8*win_id +: 8];
                    mul_r_d        = req_r_i[8*win_id +: 8];
                    ack_d[win_id]  = 1'b1;
                    start_d        = 1'b1;
                    grant_d        = win_id;
                    timer_d        = '0;
                    state_d        = StLaunch;
                end
            end
            StLaunch: begin
                timer_d = timer_q + 1'b1;
                if (timer_q == TimeoutLast) begin
                    start_d     = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_ans_d   = '0;
                    rsp_id_d    = grant_q;
                    rr_ptr_d    = rr_next;
                    state_d     = StIdle;
                end else if (!mul_ready_i) begin
                    // Multiplier has accepted the operands.
                    start_d = 1'b0;
                    state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                timer_d = timer_q + 1'b1;
                if (mul_ready_i) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_ans_d   = mul_ans_i;
                    rsp_id_d    = grant_q;
                    rr_ptr_d    = rr_next;
                    state_d     = StIdle;
                end else if (timer_q == TimeoutLast) begin
                    start_d     = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_ans_d   = '0;
                    rsp_id_d    = grant_q;
                    rr_ptr_d    = rr_next;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs: all registered except busy, which decodes the state.
    always_comb begin
        busy_o      = (state_q != StIdle);
        req_ack_o   = ack_q;
        rsp_valid_o = rsp_valid_q;
        rsp_id_o    = rsp_id_q;
        rsp_ans_o   = rsp_ans_q;
        rsp_err_o   = rsp_err_q;
        mul_m_o     = mul_m_q;
        mul_r_o     = mul_r_q;
        mul_start_o = start_q;
    end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with a behavioural 8-iteration multiplier
// stub and a response scoreboard filled in expected grant order.
module tb_mult_share_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_m;
    logic [31:0] req_r;
    logic [3:0]  req_ack;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_ans;
    logic        rsp_err;
    logic        busy;
    logic [7:0]  mul_m;
    logic [7:0]  mul_r;
    logic        mul_start;
    logic        mul_ready;
    logic [15:0] mul_ans;

    // Multiplier stub: 0 idle, 1 iterating, 2 finishing.
    logic [1:0]  s_st;
    logic [2:0]  s_cnt;
    logic        s_rdy;
    logic [15:0] s_prod;
    logic [15:0] s_ans;
    int          rdy_mode;  // 0 stub, 1 forced high, 2 forced low

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] ans;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_assert;
    int   n_fail;
    int   cyc;

    mult_share_arbiter #(.NREQ(4), .IDW(2), .TIMEOUT(31)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_m_i     (req_m),
        .req_r_i     (req_r),
        .req_ack_o   (req_ack),
        .rsp_valid_o (rsp_valid),
        .rsp_id_o    (rsp_id),
        .rsp_ans_o   (rsp_ans),
        .rsp_err_o   (rsp_err),
        .busy_o      (busy),
        .mul_m_o     (mul_m),
        .mul_r_o     (mul_r),
        .mul_start_o (mul_start),
        .mul_ready_i (mul_ready),
        .mul_ans_i   (mul_ans)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_st   <= 2'd0;
            s_cnt  <= 3'd0;
            s_rdy  <= 1'b1;
            s_prod <= 16'h0;
            s_ans  <= 16'h0;
        end else begin
            case (s_st)
                2'd0: if (mul_start) begin
                    s_rdy  <= 1'b0;
                    s_cnt  <= 3'd0;
                    s_prod <= $signed(mul_m) * $signed(mul_r);
                    s_st   <= 2'd1;
                end
                2'd1: if (s_cnt == 3'd7) s_st <= 2'd2; else s_cnt <= s_cnt + 3'd1;
                default: begin
                    s_rdy <= 1'b1;
                    s_ans <= s_prod;
                    s_st  <= 2'd0;
                end
            endcase
        end
    end

    assign mul_ready = (rdy_mode == 1) ? 1'b1 : (rdy_mode == 2) ? 1'b0 : s_rdy;
    assign mul_ans   = s_ans;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock; sample 1ns after the edge, score responses, retire acked requests.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", {31'd0, rsp_valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_id", {30'd0, rsp_id}, {30'd0, e.id});
                chk("rsp_ans", {16'd0, rsp_ans}, {16'd0, e.ans});
                chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
            end
        end
        if (req_ack != 4'd0) req_valid = req_valid & ~req_ack;
    endtask

    task automatic set_req(input int id, input logic [7:0] m, input logic [7:0] r);
        req_m[8*id +: 8] = m;
        req_r[8*id +: 8] = r;
        req_valid[id]    = 1'b1;
    endtask

    task automatic push(input logic [1:0] id, input logic [15:0] ans, input logic err);
        exp_t e;
        e.id  = id;
        e.ans = ans;
        e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic wait_ack(input string tag, input logic [3:0] expv, input int budget,
                            output int at);
        logic got;
        got = 1'b0;
        for (int n = 0; n < budget && !got; n++) begin
            step();
            if (req_ack != 4'd0) got = 1'b1;
        end
        chk(tag, {28'd0, req_ack}, {28'd0, expv});
        at = cyc;
    endtask

    task automatic wait_rsp(input string tag, input int budget, output int at);
        logic got;
        got = 1'b0;
        for (int n = 0; n < budget && !got; n++) begin
            step();
            if (rsp_valid) got = 1'b1;
        end
        chk(tag, {31'd0, got}, 32'd1);
        at = cyc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1, a2, a3, r0;
        n_assert  = 0;
        n_fail    = 0;
        cyc       = 0;
        rdy_mode  = 0;
        rst_n     = 1'b0;
        req_valid = 4'd0;
        req_m     = 32'd0;
        req_r     = 32'd0;

        // Reset state
        #12;
        chk("reset_outputs", {6'd0, req_ack, rsp_valid, rsp_id, rsp_err, busy, mul_start,
                              mul_m, mul_r}, 32'd0);
        chk("reset_ans", {16'd0, rsp_ans}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Single request: 7 * -3
        set_req(1, 8'd7, 8'hFD);
        push(2'd1, 16'hFFEB, 1'b0);
        wait_ack("single_ack", 4'b0010, 5, a0);
        chk("single_operands", {16'd0, mul_m, mul_r}, 32'h07FD);
        chk("single_busy", {31'd0, busy}, 32'd1);
        step();
        chk("single_ack_pulse", {28'd0, req_ack}, 32'd0);
        wait_rsp("single_rsp", 20, r0);
        chk("single_latency", r0 - a0, 32'd11);
        step();
        chk("single_rsp_pulse", {31'd0, rsp_valid}, 32'd0);

        // Extremes on requester 3 (leaves rr_ptr at 0)
        set_req(3, 8'h80, 8'h80);
        push(2'd3, 16'h4000, 1'b0);
        wait_ack("ext0_ack", 4'b1000, 5, a0);
        wait_rsp("ext0_rsp", 20, r0);
        set_req(3, 8'h80, 8'h7F);
        push(2'd3, 16'hC080, 1'b0);
        wait_ack("ext1_ack", 4'b1000, 5, a0);
        wait_rsp("ext1_rsp", 20, r0);
        set_req(3, 8'h00, 8'hFB);
        push(2'd3, 16'h0000, 1'b0);
        wait_ack("ext2_ack", 4'b1000, 5, a0);
        wait_rsp("ext2_rsp", 20, r0);

        // Round robin: all four held
        set_req(0, 8'd3, 8'd4);
        set_req(1, 8'hFE, 8'd5);
        set_req(2, 8'd10, 8'hF6);
        set_req(3, 8'hF9, 8'hF9);
        push(2'd0, 16'h000C, 1'b0);
        push(2'd1, 16'hFFF6, 1'b0);
        push(2'd2, 16'hFF9C, 1'b0);
        push(2'd3, 16'h0031, 1'b0);
        wait_ack("rr_ack0", 4'b0001, 5, a0);
        wait_ack("rr_ack1", 4'b0010, 20, a1);
        chk("rr_gap01", a1 - a0, 32'd12);
        wait_ack("rr_ack2", 4'b0100, 20, a2);
        chk("rr_gap12", a2 - a1, 32'd12);
        wait_ack("rr_ack3", 4'b1000, 20, a3);
        chk("rr_gap23", a3 - a2, 32'd12);
        wait_rsp("rr_rsp3", 20, r0);

        // Requests 0 and 2 with rr_ptr at 0
        set_req(0, 8'd1, 8'd1);
        set_req(2, 8'd2, 8'hFF);
        push(2'd0, 16'h0001, 1'b0);
        push(2'd2, 16'hFFFE, 1'b0);
        wait_ack("pair02_first", 4'b0001, 5, a0);
        wait_ack("pair02_second", 4'b0100, 20, a1);
        wait_rsp("pair02_rsp", 20, r0);

        // Requests 3 and 0 with rr_ptr at 3
        set_req(3, 8'h7F, 8'h7F);
        set_req(0, 8'hFF, 8'hFF);
        push(2'd3, 16'h3F01, 1'b0);
        push(2'd0, 16'h0001, 1'b0);
        wait_ack("pair30_first", 4'b1000, 5, a0);
        wait_ack("pair30_second", 4'b0001, 20, a1);
        wait_rsp("pair30_rsp", 20, r0);

        // Timeout: ready stuck high
        rdy_mode = 1;
        set_req(2, 8'd9, 8'd9);
        push(2'd2, 16'h0000, 1'b1);
        wait_ack("to_ack", 4'b0100, 5, a0);
        wait_rsp("to_rsp", 40, r0);
        chk("to_latency", r0 - a0, 32'd31);
        chk("to_start_low", {31'd0, mul_start}, 32'd0);
        for (int n = 0; n < 12; n++) step();
        rdy_mode = 0;
        set_req(1, 8'd5, 8'd6);
        push(2'd1, 16'h001E, 1'b0);
        wait_ack("after_to_ack", 4'b0010, 5, a0);
        wait_rsp("after_to_rsp", 20, r0);
        chk("after_to_latency", r0 - a0, 32'd11);

        // Ready gating
        rdy_mode = 2;
        set_req(0, 8'd12, 8'd12);
        push(2'd0, 16'h0090, 1'b0);
        for (int n = 0; n < 3; n++) begin
            step();
            chk("gate_no_ack", {28'd0, req_ack}, 32'd0);
            chk("gate_not_busy", {31'd0, busy}, 32'd0);
        end
        rdy_mode = 0;
        wait_ack("gate_release_ack", 4'b0001, 1, a0);
        wait_rsp("gate_rsp", 20, r0);

        // Reset during WAIT_DONE
        set_req(2, 8'd9, 8'd9);
        wait_ack("rst_inflight_ack", 4'b0100, 5, a0);
        for (int n = 0; n < 5; n++) step();
        chk("rst_pre_busy", {31'd0, busy}, 32'd1);
        #2;
        rst_n     = 1'b0;
        req_valid = 4'd0;
        #1;
        chk("rst_mid_outputs", {6'd0, req_ack, rsp_valid, rsp_id, rsp_err, busy, mul_start,
                                mul_m, mul_r}, 32'd0);
        chk("rst_mid_ans", {16'd0, rsp_ans}, 32'd0);
        #20;
        rst_n = 1'b1;
        step();
        set_req(3, 8'hFD, 8'hFD);
        push(2'd3, 16'h0009, 1'b0);
        wait_ack("post_rst_ack", 4'b1000, 5, a0);
        wait_rsp("post_rst_rsp", 20, r0);
        chk("post_rst_latency", r0 - a0, 32'd11);
        for (int n = 0; n < 3; n++) step();
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
